// File: rtl/spi_master_tx_fifo_if.sv
// Bus interface for spi_master_tx_fifo.
// Carries the host write port, the fill-level/event status and the
// request/valid/empty handshake toward the SPI master.
// The slave modport is the FIFO's view; master is the view of whoever drives it.
interface spi_master_tx_fifo_if #(
    parameter int data_width_g = 8,
    parameter int depth_g      = 16
);
    localparam int used_w = $clog2(depth_g) + 1;

    // host side
    logic [data_width_g-1:0] din;
    logic                    din_valid;
    logic                    full;
    logic                    almost_full;
    logic [used_w-1:0]       used;
    logic                    overflow;

    // SPI master side
    logic                    fifo_req_data;
    logic [data_width_g-1:0] fifo_din;
    logic                    fifo_din_valid;
    logic                    fifo_empty;
    logic                    underflow;

    modport slave (
        input  din, din_valid, fifo_req_data,
        output full, almost_full, used, overflow,
        output fifo_din, fifo_din_valid, fifo_empty, underflow
    );

    modport master (
        output din, din_valid, fifo_req_data,
        input  full, almost_full, used, overflow,
        input  fifo_din, fifo_din_valid, fifo_empty, underflow
    );
endinterface

// File: rtl/spi_master_tx_fifo.sv
// spi_master_tx_fifo: transmit-data FIFO feeding the SPI master.
// Circular buffer with separate write/read pointers and an up/down fill
// counter. Reads have a fixed latency of one cycle; every status output is
// registered and reflects the state after the current edge.
// Optional feature: define SPI_TX_FIFO_FLUSH_EN to add a synchronous flush
// input that empties the FIFO and discards same-cycle writes/requests.
module spi_master_tx_fifo #(
    parameter int data_width_g  = 8,
    parameter int depth_g       = 16,
    parameter int almost_full_g = 12
) (
    input  logic clk,
    input  logic rst,           // asynchronous, active low
`ifdef SPI_TX_FIFO_FLUSH_EN
    input  logic flush,
`endif
    spi_master_tx_fifo_if.slave bus
);

    localparam int addr_w = $clog2(depth_g);
    localparam int used_w = addr_w + 1;

    // Storage is deliberately not reset so it can map onto RAM.
    logic [data_width_g-1:0] mem [depth_g];

    logic [addr_w-1:0]       wr_ptr_q, wr_ptr_d;
    logic [addr_w-1:0]       rd_ptr_q, rd_ptr_d;
    logic [used_w-1:0]       used_q, used_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    almost_full_q, almost_full_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic [data_width_g-1:0] dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;

    logic                    flush_w;
    logic                    rd_en;
    logic                    wr_en;

`ifdef SPI_TX_FIFO_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Next-state: accept/reject decisions, pointer and count updates, status.
    always_comb begin
        // A request is served only when words are present. A write into a full
        // FIFO is still accepted if a read frees the slot on the same edge.
        // No bypass: a write into an empty FIFO cannot satisfy a same-cycle request.
        rd_en = bus.fifo_req_data && !empty_q && !flush_w;
        wr_en = bus.din_valid && (!full_q || rd_en) && !flush_w;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + addr_w'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + addr_w'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   used_d = used_q + used_w'(1);
            2'b01:   used_d = used_q - used_w'(1);
            default: used_d = used_q;
        endcase

        if (flush_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
        end

        overflow_d  = bus.din_valid && full_q && !rd_en && !flush_w;
        underflow_d = bus.fifo_req_data && empty_q && !flush_w;

        // Output word is captured on the read edge and held otherwise.
        dout_valid_d = rd_en;
        dout_d       = rd_en ? mem[rd_ptr_q] : dout_q;

        full_d        = (used_d == used_w'(depth_g));
        empty_d       = (used_d == '0);
        almost_full_d = (used_d >= used_w'(almost_full_g));
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    // State registers; reset discards queued words and cancels pending output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            used_q        <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            used_q        <= used_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
        end
    end

    assign bus.full           = full_q;
    assign bus.almost_full    = almost_full_q;
    assign bus.used           = used_q;
    assign bus.overflow       = overflow_q;
    assign bus.fifo_din       = dout_q;
    assign bus.fifo_din_valid = dout_valid_q;
    assign bus.fifo_empty     = empty_q;
    assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_spi_master_tx_fifo.sv
// Testbench for spi_master_tx_fifo (depth 16, width 8, almost-full at 12).
// Expected output words are queued when a request is issued; a monitor on
// the falling clock edge pops and compares whenever fifo_din_valid is high.
module tb_spi_master_tx_fifo;

    logic clk;
    logic rst;
`ifdef SPI_TX_FIFO_FLUSH_EN
    logic flush;
`endif

    spi_master_tx_fifo_if #(.data_width_g(8), .depth_g(16)) bus_if ();

    spi_master_tx_fifo #(
        .data_width_g (8),
        .depth_g      (16),
        .almost_full_g(12)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef SPI_TX_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one line per delivered word.
    always @(negedge clk) begin
        if (rst && bus_if.fifo_din_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got word %0h, expected no output", bus_if.fifo_din);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("rx word %02h (expected %02h)", bus_if.fifo_din, e);
                check("rx_data", {24'h0, bus_if.fifo_din}, {24'h0, e});
            end
        end
    end

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rq);
        bus_if.din_valid     = wv;
        bus_if.din           = wd;
        bus_if.fifo_req_data = rq;
        @(posedge clk);
        #1;
        bus_if.din_valid     = 1'b0;
        bus_if.fifo_req_data = 1'b0;
    endtask

    task automatic expect_drained(input string name);
        step(1'b0, 8'h00, 1'b0);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.din           = 8'h00;
        bus_if.din_valid     = 1'b0;
        bus_if.fifo_req_data = 1'b0;
`ifdef SPI_TX_FIFO_FLUSH_EN
        flush = 1'b0;
`endif
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset then idle
        check("rst_empty", bus_if.fifo_empty, 1);
        check("rst_full", bus_if.full, 0);
        check("rst_used", bus_if.used, 0);
        check("rst_valid", bus_if.fifo_din_valid, 0);
        check("rst_din", bus_if.fifo_din, 0);
        step(1'b0, 8'h00, 1'b0);
        check("idle_empty", bus_if.fifo_empty, 1);

        // Three writes, three back-to-back requests
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        check("three_used", bus_if.used, 3);
        check("three_empty", bus_if.fifo_empty, 0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        step(1'b0, 8'h00, 1'b1);
        check("b2b_valid1", bus_if.fifo_din_valid, 1);
        step(1'b0, 8'h00, 1'b1);
        check("b2b_valid2", bus_if.fifo_din_valid, 1);
        step(1'b0, 8'h00, 1'b1);
        check("b2b_valid3", bus_if.fifo_din_valid, 1);
        check("b2b_used", bus_if.used, 0);
        check("b2b_empty", bus_if.fifo_empty, 1);
        expect_drained("b2b_drained");
        check("hold_valid", bus_if.fifo_din_valid, 0);
        check("hold_din", bus_if.fifo_din, 8'hA3);

        // Fill to 16, almost_full from the 12th write, then an overflowing write
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(i - 1);
            step(1'b1, d, 1'b0);
            check("fill_used", bus_if.used, i);
            check("fill_almost_full", bus_if.almost_full, (i >= 12) ? 1 : 0);
            check("fill_full", bus_if.full, (i == 16) ? 1 : 0);
        end
        step(1'b1, 8'hEE, 1'b0);
        check("ovf_pulse", bus_if.overflow, 1);
        check("ovf_used", bus_if.used, 16);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_clear", bus_if.overflow, 0);

        // Full: write 0x55 with a simultaneous request
        exp_q.push_back(8'h10);
        step(1'b1, 8'h55, 1'b1);
        check("fullrw_ovf", bus_if.overflow, 0);
        check("fullrw_used", bus_if.used, 16);
        check("fullrw_valid", bus_if.fifo_din_valid, 1);
        for (int i = 1; i <= 15; i++) exp_q.push_back(8'h10 + 8'(i));
        exp_q.push_back(8'h55);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        check("fullrw_empty", bus_if.fifo_empty, 1);
        expect_drained("fullrw_drained");

        // Request while empty, without and with a simultaneous write
        step(1'b0, 8'h00, 1'b1);
        check("udf_pulse", bus_if.underflow, 1);
        check("udf_valid", bus_if.fifo_din_valid, 0);
        check("udf_used", bus_if.used, 0);
        step(1'b0, 8'h00, 1'b0);
        check("udf_clear", bus_if.underflow, 0);
        step(1'b1, 8'h3C, 1'b1);
        check("udfw_pulse", bus_if.underflow, 1);
        check("udfw_valid", bus_if.fifo_din_valid, 0);
        check("udfw_used", bus_if.used, 1);
        check("udfw_empty", bus_if.fifo_empty, 0);
        exp_q.push_back(8'h3C);
        step(1'b0, 8'h00, 1'b1);
        check("udfw_read_empty", bus_if.fifo_empty, 1);
        expect_drained("udfw_drained");

        // Random interleaving of 40 words across pointer wrap
        begin
            int  wn;
            bit  done;
            wn   = 0;
            done = 1'b0;
            for (int cyc = 0; cyc < 600 && !done; cyc++) begin
                logic       wv, rq;
                logic [7:0] d;
                wv = (wn < 40) && ($urandom_range(0, 2) != 0);
                rq = ($urandom_range(0, 1) != 0);
                d  = 8'hC0 + 8'(wn);
                if (rq && model_q.size() > 0) exp_q.push_back(model_q.pop_front());
                if (wv && model_q.size() < 16) begin
                    model_q.push_back(d);
                    wn++;
                end
                step(wv, d, rq);
                check("rand_used", bus_if.used, model_q.size());
                done = (wn == 40) && (model_q.size() == 0);
            end
            check("rand_complete", done, 1);
        end
        expect_drained("rand_drained");

        // Reset mid-stream with 5 words queued and a read in flight
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] d;
            d = 8'(i);
            step(1'b1, d, 1'b0);
        end
        check("pre_rst_used", bus_if.used, 5);
        step(1'b0, 8'h00, 1'b1);   // valid now high; reset must cancel it
        check("pre_rst_valid", bus_if.fifo_din_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_empty", bus_if.fifo_empty, 1);
        check("async_rst_used", bus_if.used, 0);
        check("async_rst_valid", bus_if.fifo_din_valid, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        check("post_rst_used", bus_if.used, 1);
        exp_q.push_back(8'h77);
        step(1'b0, 8'h00, 1'b1);
        expect_drained("post_rst_drained");
        check("post_rst_empty", bus_if.fifo_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
